// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard and stall controller for a 5-stage pipeline.
//   It resolves three conditions in priority order:
//     1. data-memory stall
//     2. taken branch (flush)
//     3. load-use hazard (bubble)
//   A data-memory wait that lasts too long ends in a sticky ERROR state.
//   Only reset leaves ERROR.
//
// Parameters
//   MEM_TIMEOUT (2..255) : consecutive data-memory stall cycles tolerated
//                          before ERROR
//
// Optional feature
//   HAZARD_PERF_CNT_EN   : when defined, enables the saturating stall and
//                          flush performance counters. When it is not
//                          defined, stall_cnt and flush_cnt read 0.
//
// Ports
//   clk, reset            : rising-edge clock; asynchronous active-low reset
//   id_rs, id_rt          : source registers of the instruction in ID
//   id_ex_memRead/id_ex_rt: load flag and destination of the ID/EX instruction
//   ex_mem_branch/zero    : branch control and ALU zero flag in EX/MEM
//   ex_mem_memAccess      : EX/MEM instruction accesses data memory
//   mem_ready             : data memory completes the access this cycle
//   pc_write, if_id_write : PC and IF/ID update enables
//   *_flush               : load a bubble into that pipeline register
//   ex_mem_hold           : EX/MEM and MEM/WB keep their contents
//   pc_src                : select the branch target for the PC
//   mem_error             : sticky memory-timeout flag (registered)
//   state                 : FSM state, for debug
//   stall_cnt, flush_cnt  : performance counters
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_ex_memRead,
    input  logic [4:0]  id_ex_rt,
    input  logic        ex_mem_branch,
    input  logic        ex_mem_zero,
    input  logic        ex_mem_memAccess,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        ex_mem_hold,
    output logic        pc_src,
    output logic        mem_error,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_nxt;
    logic [7:0] w_wait_inc;
    logic       r_mem_error;
    logic       w_mem_error_nxt;

    logic w_mem_stall;
    logic w_branch;
    logic w_load_use;

    // Outputs produced by the RUN priority rules (branch, load-use, normal).
    // RUN and MEM_WAIT with mem_ready=1 share these outputs.
    logic w_run_pc_write;
    logic w_run_if_id_write;
    logic w_run_id_ex_flush;

    assign w_mem_stall = ex_mem_memAccess & ~mem_ready;
    assign w_branch    = ex_mem_branch & ex_mem_zero;
    // Register 0 is hard-wired, so it never creates a dependency.
    assign w_load_use  = id_ex_memRead && (id_ex_rt != 5'd0) &&
                         ((id_ex_rt == id_rs) || (id_ex_rt == id_rt));

    // A taken branch flushes the dependent instruction, so the branch
    // overrides the load-use bubble.
    assign w_run_pc_write    = w_branch | ~w_load_use;
    assign w_run_if_id_write = w_branch | ~w_load_use;
    assign w_run_id_ex_flush = w_branch | w_load_use;

    // wait_cnt holds the number of stall cycles already seen. The cycle
    // being evaluated is included through w_wait_inc. With this count, a
    // continuous stall that starts in cycle 0 reaches ERROR in cycle
    // MEM_TIMEOUT.
    assign w_wait_inc = r_wait_cnt + 8'd1;

    always_comb begin
        pc_write        = 1'b0;
        if_id_write     = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        ex_mem_flush    = 1'b0;
        ex_mem_hold     = 1'b0;
        pc_src          = 1'b0;
        w_state_nxt     = r_state;
        w_wait_nxt      = r_wait_cnt;
        w_mem_error_nxt = r_mem_error;

        case (r_state)
            INIT: begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                w_wait_nxt   = '0;
                w_state_nxt  = RUN;
            end

            RUN: begin
                // When the stall condition is unknown, the default branch
                // applies and the state stays at RUN.
                case (w_mem_stall)
                    1'b1: begin
                        ex_mem_hold = 1'b1;
                        w_wait_nxt  = 8'd1;
                        w_state_nxt = MEM_WAIT;
                    end
                    default: begin
                        pc_write     = w_run_pc_write;
                        if_id_write  = w_run_if_id_write;
                        if_id_flush  = w_branch;
                        id_ex_flush  = w_run_id_ex_flush;
                        ex_mem_flush = w_branch;
                        pc_src       = w_branch;
                    end
                endcase
            end

            MEM_WAIT: begin
                case (mem_ready)
                    1'b1: begin
                        pc_write     = w_run_pc_write;
                        if_id_write  = w_run_if_id_write;
                        if_id_flush  = w_branch;
                        id_ex_flush  = w_run_id_ex_flush;
                        ex_mem_flush = w_branch;
                        pc_src       = w_branch;
                        w_wait_nxt   = '0;
                        w_state_nxt  = RUN;
                    end
                    1'b0: begin
                        ex_mem_hold = 1'b1;
                        if (w_wait_inc == TIMEOUT) begin
                            w_state_nxt     = ERROR;
                            w_mem_error_nxt = 1'b1;
                        end else begin
                            w_wait_nxt = w_wait_inc;
                        end
                    end
                    default: begin
                        // An unknown mem_ready keeps the pipeline held and
                        // leaves the state unchanged.
                        ex_mem_hold = 1'b1;
                    end
                endcase
            end

            ERROR: begin
                ex_mem_hold = 1'b1;
            end

            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= INIT;
            r_wait_cnt  <= '0;
            r_mem_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_mem_error <= w_mem_error_nxt;
        end
    end

    assign state     = r_state;
    assign mem_error = r_mem_error;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        w_stall_evt;

    assign w_stall_evt = ((r_state == RUN) || (r_state == MEM_WAIT)) && !pc_write;

    // pc_src is high only while a taken branch flushes, so it marks the
    // flush events.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (pc_src && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Self-checking bench for pipe_hazard_ctrl. The DUT uses MEM_TIMEOUT=4.
//   Each scenario table row drives one cycle of inputs. When the row is
//   driven, its expected outputs go onto a scoreboard queue. They are popped
//   and compared at the falling edge of the same cycle.
//   Observation vector layout (10 bits):
//     {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
//      ex_mem_hold, pc_src, mem_error, state[1:0]}
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_ex_memRead = 1'b0;
    logic [4:0]  id_ex_rt = '0;
    logic        ex_mem_branch = 1'b0;
    logic        ex_mem_zero = 1'b0;
    logic        ex_mem_memAccess = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
    logic        ex_mem_hold, pc_src, mem_error;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_ex_memRead(id_ex_memRead), .id_ex_rt(id_ex_rt),
        .ex_mem_branch(ex_mem_branch), .ex_mem_zero(ex_mem_zero),
        .ex_mem_memAccess(ex_mem_memAccess), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .ex_mem_hold(ex_mem_hold),
        .pc_src(pc_src), .mem_error(mem_error), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Expected observation vectors
    localparam logic [9:0] E_INIT = 10'b00_111_0_0_0_00;
    localparam logic [9:0] E_RUN  = 10'b11_000_0_0_0_01;
    localparam logic [9:0] E_LU   = 10'b00_010_0_0_0_01;
    localparam logic [9:0] E_BR   = 10'b11_111_0_1_0_01;
    localparam logic [9:0] E_STR  = 10'b00_000_1_0_0_01;
    localparam logic [9:0] E_STW  = 10'b00_000_1_0_0_10;
    localparam logic [9:0] E_MWR  = 10'b11_000_0_0_0_10;
    localparam logic [9:0] E_BRW  = 10'b11_111_0_1_0_10;
    localparam logic [9:0] E_ERR  = 10'b00_000_1_0_1_11;
    localparam logic [9:0] M_ALL  = 10'b11_1111_1111;
    // if_id_write is not constrained during a taken branch
    localparam logic [9:0] M_BR   = 10'b10_1111_1111;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [15:0] EXP_STALL3 = 16'd3;
    localparam logic [15:0] EXP_FLUSH3 = 16'd3;
`else
    localparam logic [15:0] EXP_STALL3 = 16'd0;
    localparam logic [15:0] EXP_FLUSH3 = 16'd0;
`endif

    typedef struct {
        string      name;
        logic [4:0] rs, rt, exrt;
        logic       mr, br, z, ma, rdy;
        logic [9:0] exp, mask;
    } stim_t;

    typedef struct {
        string      name;
        logic [9:0] exp, mask;
    } sb_t;

    sb_t sb_q[$];

    function automatic stim_t mk(string n, logic [4:0] rs, logic [4:0] rt,
                                 logic mr, logic [4:0] exrt, logic br, logic z,
                                 logic ma, logic rdy, logic [9:0] e, logic [9:0] m);
        stim_t s;
        s.name = n; s.rs = rs; s.rt = rt; s.mr = mr; s.exrt = exrt;
        s.br = br; s.z = z; s.ma = ma; s.rdy = rdy; s.exp = e; s.mask = m;
        return s;
    endfunction

    function automatic logic [9:0] obs();
        return {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
                ex_mem_hold, pc_src, mem_error, state};
    endfunction

    // Drive one cycle of stimulus shortly after the rising edge and
    // queue its expectation.
    task automatic apply(input stim_t s);
        sb_t e;
        @(posedge clk);
        #1;
        id_rs = s.rs; id_rt = s.rt; id_ex_memRead = s.mr; id_ex_rt = s.exrt;
        ex_mem_branch = s.br; ex_mem_zero = s.z;
        ex_mem_memAccess = s.ma; mem_ready = s.rdy;
        e.name = s.name; e.exp = s.exp; e.mask = s.mask;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        id_rs = '0; id_rt = '0; id_ex_memRead = 1'b0; id_ex_rt = '0;
        ex_mem_branch = 1'b0; ex_mem_zero = 1'b0;
        ex_mem_memAccess = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        stim_t rows[$];
        sb_t   e;
        @(negedge clk);
        n_checks++;
        if (obs() !== E_INIT) begin
            n_fail++;
            $display("FAIL reset_hold: got %b expected %b", obs(), E_INIT);
        end
        n_checks++;
        if ({stall_cnt, flush_cnt} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %h/%h expected 0/0", stall_cnt, flush_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs() !== E_INIT) begin
            n_fail++;
            $display("FAIL init_after_release: got %b expected %b", obs(), E_INIT);
        end
        rows.push_back(mk("run_first", 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, M_ALL));
        rows.push_back(mk("run_second", 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, M_ALL));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if ((obs() & e.mask) !== (e.exp & e.mask)) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t rows[$];
        sb_t   e;
        do_reset();
        rows.push_back(mk("lu_rs_match", 5, 0, 1, 5, 0, 0, 0, 0, E_LU, M_ALL));
        rows.push_back(mk("lu_cleared", 5, 0, 0, 5, 0, 0, 0, 0, E_RUN, M_ALL));
        rows.push_back(mk("lu_reg0", 0, 0, 1, 0, 0, 0, 0, 0, E_RUN, M_ALL));
        rows.push_back(mk("lu_rt_match", 1, 7, 1, 7, 0, 0, 0, 0, E_LU, M_ALL));
        rows.push_back(mk("lu_no_match", 1, 2, 1, 7, 0, 0, 0, 0, E_RUN, M_ALL));
        rows.push_back(mk("lu_not_load", 7, 7, 0, 7, 0, 0, 0, 0, E_RUN, M_ALL));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if ((obs() & e.mask) !== (e.exp & e.mask)) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
            end
        end
    endtask

    task automatic test_branch_priority();
        stim_t rows[$];
        sb_t   e;
        do_reset();
        rows.push_back(mk("br_over_lu", 5, 0, 1, 5, 1, 1, 0, 0, E_BR, M_BR));
        rows.push_back(mk("br_not_taken_lu", 5, 0, 1, 5, 1, 0, 0, 0, E_LU, M_ALL));
        rows.push_back(mk("br_alone", 0, 0, 0, 0, 1, 1, 0, 0, E_BR, M_BR));
        rows.push_back(mk("memstall_over_br", 0, 0, 0, 0, 1, 1, 1, 0, E_STR, M_ALL));
        rows.push_back(mk("br_in_wait_ready", 0, 0, 0, 0, 1, 1, 1, 1, E_BRW, M_BR));
        rows.push_back(mk("br_back_to_run", 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, M_ALL));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if ((obs() & e.mask) !== (e.exp & e.mask)) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
            end
        end
        n_checks++;
        if (flush_cnt !== EXP_FLUSH3) begin
            n_fail++;
            $display("FAIL flush_cnt: got %0d expected %0d", flush_cnt, EXP_FLUSH3);
        end
    endtask

    // Three stalled cycles, then ready in cycle 3. This is the last cycle
    // before the timeout for MEM_TIMEOUT=4.
    task automatic test_mem_stall();
        stim_t rows[$];
        sb_t   e;
        do_reset();
        rows.push_back(mk("ms_c0_run", 0, 0, 0, 0, 0, 0, 1, 0, E_STR, M_ALL));
        rows.push_back(mk("ms_c1_wait", 0, 0, 0, 0, 0, 0, 1, 0, E_STW, M_ALL));
        rows.push_back(mk("ms_c2_wait", 0, 0, 0, 0, 0, 0, 1, 0, E_STW, M_ALL));
        rows.push_back(mk("ms_c3_ready", 0, 0, 0, 0, 0, 0, 1, 1, E_MWR, M_ALL));
        rows.push_back(mk("ms_c4_run", 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, M_ALL));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if ((obs() & e.mask) !== (e.exp & e.mask)) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
            end
        end
        n_checks++;
        if (stall_cnt !== EXP_STALL3) begin
            n_fail++;
            $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, EXP_STALL3);
        end
    endtask

    task automatic test_timeout();
        stim_t rows[$];
        sb_t   e;
        // Reset in the middle of a wait leaves no hold behind.
        do_reset();
        rows.push_back(mk("rw_c0_run", 0, 0, 0, 0, 0, 0, 1, 0, E_STR, M_ALL));
        rows.push_back(mk("rw_c1_wait", 0, 0, 0, 0, 0, 0, 1, 0, E_STW, M_ALL));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if ((obs() & e.mask) !== (e.exp & e.mask)) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
            end
        end
        rows.delete();
        do_reset();
        rows.push_back(mk("rw_after_reset", 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, M_ALL));
        rows.push_back(mk("to_c0_run", 0, 0, 0, 0, 0, 0, 1, 0, E_STR, M_ALL));
        rows.push_back(mk("to_c1_wait", 0, 0, 0, 0, 0, 0, 1, 0, E_STW, M_ALL));
        rows.push_back(mk("to_c2_wait", 0, 0, 0, 0, 0, 0, 1, 0, E_STW, M_ALL));
        rows.push_back(mk("to_c3_wait", 0, 0, 0, 0, 0, 0, 1, 0, E_STW, M_ALL));
        rows.push_back(mk("to_c4_error", 0, 0, 0, 0, 0, 0, 1, 0, E_ERR, M_ALL));
        rows.push_back(mk("to_error_sticky", 0, 0, 0, 0, 0, 0, 1, 1, E_ERR, M_ALL));
        rows.push_back(mk("to_error_idle", 0, 0, 0, 0, 0, 0, 0, 0, E_ERR, M_ALL));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if ((obs() & e.mask) !== (e.exp & e.mask)) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
            end
        end
        // Assert reset between clock edges; it must act immediately.
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs() !== E_INIT) begin
            n_fail++;
            $display("FAIL async_reset_in_error: got %b expected %b", obs(), E_INIT);
        end
        @(negedge clk);
        reset = 1'b1;
        rows.delete();
        rows.push_back(mk("run_after_error", 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, M_ALL));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if ((obs() & e.mask) !== (e.exp & e.mask)) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_use();
        test_branch_priority();
        test_mem_stall();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
